// File: rtl/dmem_dump_pkg.sv
// Shared types and constants for the DMEM dump unit.
package dmem_dump_pkg;

  localparam int DMEM_WORDS = 1024;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int BYTE_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // One streamed record at the default geometry.
  typedef struct packed {
    logic [DEF_ADDR_W+BYTE_SHIFT-1:0] byte_addr;
    logic [DEF_DATA_W-1:0]            data;
    logic                             last;
  } record_t;

  // Word index to byte address.
  function automatic logic [DEF_ADDR_W+BYTE_SHIFT-1:0] word_to_byte(input logic [DEF_ADDR_W-1:0] idx);
    return {idx, {BYTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/dmem_dump_unit_if.sv
// Control, DMEM read port and record stream of the dump unit in one bundle.
interface dmem_dump_unit_if
  import dmem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // control
  logic                       start;
  logic [ADDR_W-1:0]          base_idx;
  logic [ADDR_W:0]            count;
  logic                       busy;
  logic                       done;
  // DMEM read port
  logic                       mem_re;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_rdata;
  // record stream
  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_W+BYTE_SHIFT-1:0] out_byte_addr;
  logic [DATA_W-1:0]          out_data;
  logic                       out_last;

  // Dump unit side.
  modport slave (
    input  start, base_idx, count, mem_rdata, out_ready,
    output busy, done, mem_re, mem_addr, out_valid, out_byte_addr, out_data, out_last
  );

  // Controller / memory / consumer side.
  modport master (
    output start, base_idx, count, mem_rdata, out_ready,
    input  busy, done, mem_re, mem_addr, out_valid, out_byte_addr, out_data, out_last
  );
endinterface

// File: rtl/dump_skid_fifo.sv
// Two-entry valid/ready FIFO; a push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module dump_skid_fifo #(
  parameter int W = 45
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   occ_o
);

  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] occ_q, occ_d;
  logic       do_pop, do_push;

  assign empty_o = (occ_q == 2'd0);
  assign full_o  = (occ_q == 2'd2);
  assign occ_o   = occ_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [W-1:0] data_q;
      // Storage slot gi: written when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          data_q <= '0;
        end else if (do_push && (wr_ptr_q == 1'(gi))) begin
          data_q <= push_data_i;
        end
      end
    end
  endgenerate

  assign head_o = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;

  // Occupancy next state; push+pop together leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!do_push && do_pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/dmem_dump_unit.sv
// Walks a window of DMEM through a synchronous read port and streams (byte address, data) records.
module dmem_dump_unit
  import dmem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_dump_unit_if.slave  bus
);

  localparam int BA_W  = ADDR_W + BYTE_SHIFT;
  localparam int REC_W = BA_W + DATA_W + 1;
  localparam logic [ADDR_W:0] CNT_ZERO = '0;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]    rd_left_q, rd_left_d;
  logic [ADDR_W:0]    wr_left_q, wr_left_d;
  logic               infl_q;
  logic [ADDR_W-1:0]  infl_idx_q;
  logic               infl_last_q;

  logic               issue;
  logic               pop;
  logic               room;
  logic [REC_W-1:0]   push_rec;
  logic [REC_W-1:0]   head_rec;
  logic               fifo_full, fifo_empty;
  logic [1:0]         fifo_occ;

  assign pop = !fifo_empty && bus.out_ready;

  // A read may go out when the buffer plus the read in flight leave a free slot,
  // or when the head retires this cycle and frees one; that keeps full rate.
  assign room = (!fifo_full && !(infl_q && (fifo_occ != 2'd0))) || pop;

  // Next-state, read issue and retire accounting.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    issue     = 1'b0;
    if (pop) begin
      wr_left_d = wr_left_q - CNT_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.count != CNT_ZERO) begin
            rd_idx_d  = bus.base_idx;
            rd_left_d = bus.count;
            wr_left_d = bus.count;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (room && (rd_left_q != CNT_ZERO)) begin
          issue     = 1'b1;
          rd_idx_d  = rd_idx_q + 1'b1;
          rd_left_d = rd_left_q - CNT_ONE;
          if (rd_left_q == CNT_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // wr_left_d reaching zero implies the buffer empties at this edge.
        if (!infl_q && (wr_left_d == CNT_ZERO)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, walk counters and the in-flight read tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rd_idx_q    <= '0;
      rd_left_q   <= '0;
      wr_left_q   <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      infl_q    <= issue;
      if (issue) begin
        infl_idx_q  <= rd_idx_q;
        infl_last_q <= (rd_left_q == CNT_ONE);
      end
    end
  end

  assign push_rec = {infl_idx_q, {BYTE_SHIFT{1'b0}}, bus.mem_rdata, infl_last_q};

  dump_skid_fifo #(.W(REC_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (infl_q),
    .push_data_i (push_rec),
    .pop_i       (pop),
    .head_o      (head_rec),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occ_o       (fifo_occ)
  );

  assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done          = (state_q == ST_FIN);
  assign bus.mem_re        = issue;
  assign bus.mem_addr      = rd_idx_q;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_byte_addr = head_rec[REC_W-1 -: BA_W];
  assign bus.out_data      = head_rec[DATA_W:1];
  assign bus.out_last      = head_rec[0];

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Directed and randomized bench for dmem_dump_unit with a DMEM model and a record-list reference.
module tb_dmem_dump_unit;
  import dmem_dump_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_dump_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_dump_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // DMEM model: one-cycle synchronous read.
  logic [DW-1:0] dmem [DMEM_WORDS];
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  record_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int j);
    logic [5:0] pat;
    pat = 6'b101001; // bit k = ready in step k: 1,0,0,1,0,1
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[j % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one dump and checks every record, timing, stalls and buffer bound.
  task automatic run_dump(input int base, input int cnt, input int rmode, input bit poke);
    int  acc, first_v, last_acc, outstanding, budget;
    bit  stall_p, seen_done;
    logic [AW+1:0] sa;
    logic [DW-1:0] sd;
    record_t e;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      int w;
      record_t r;
      w = (base + i) % DMEM_WORDS;
      r.byte_addr = word_to_byte(w[AW-1:0]);
      r.data      = dmem[w];
      r.last      = (i == cnt - 1);
      exp_q.push_back(r);
    end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.base_idx = base[AW-1:0];
    bus.count    = cnt[AW:0];
    bus.out_ready = 1'b1;
    acc = 0; first_v = -1; last_acc = -1; outstanding = 0;
    stall_p = 1'b0; seen_done = 1'b0; sa = '0; sd = '0;
    budget = cnt * 4 + 40;
    for (int j = 0; j < budget && !seen_done; j++) begin
      @(negedge clk);
      bus.start = poke && (j == 1);
      if (poke && j == 1) begin
        bus.count    = 11'd8;
        bus.base_idx = 10'd100;
      end
      bus.out_ready = rdy(rmode, j);
      #1;
      if (j == 0) chk("busy_after_start", bus.busy, cnt > 0);
      if (cnt == 0) chk("no_valid_count0", bus.out_valid, 1'b0);
      if (stall_p) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_data", bus.out_data, sd);
        chk("stall_addr", bus.out_byte_addr, sa);
      end
      if (bus.out_valid && first_v < 0) begin
        first_v = j;
        chk("first_valid_cycle", j, 2);
      end
      outstanding += int'(bus.mem_re);
      if (bus.out_valid && bus.out_ready) outstanding--;
      if (bus.mem_re) chk("buffer_bound", outstanding <= 2, 1'b1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_record", acc + 1, cnt);
        end else begin
          e = exp_q.pop_front();
          chk("rec_addr", bus.out_byte_addr, e.byte_addr);
          chk("rec_data", bus.out_data, e.data);
          chk("rec_last", bus.out_last, e.last);
          if (rmode == 0) chk("full_rate_cycle", j, 2 + acc);
        end
        acc++;
        last_acc = j;
      end
      stall_p = bus.out_valid && !bus.out_ready;
      sa = bus.out_byte_addr;
      sd = bus.out_data;
      if (bus.done) begin
        seen_done = 1'b1;
        chk("done_cycle", j, (cnt == 0) ? 0 : last_acc + 1);
        chk("record_count", acc, cnt);
      end
    end
    chk("done_seen", seen_done, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) chk("done_one_cycle", bus.done, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_valid", bus.out_valid, 1'b0);
      chk("idle_mem_re", bus.mem_re, 1'b0);
    end
    $display("dump base=%0d count=%0d ready_mode=%0d records=%0d", base, cnt, rmode, acc);
  endtask

  initial begin
    int acc;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.base_idx  = '0;
    bus.count     = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = $urandom;
    dmem[0] = 32'd10; dmem[1] = 32'd20; dmem[2] = 32'd30; dmem[3] = 32'd40;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_mem_re", bus.mem_re, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_addr", bus.out_byte_addr, '0);
    chk("rst_data", bus.out_data, '0);

    run_dump(0, 4, 0, 1'b0);      // full rate
    run_dump(0, 4, 1, 1'b0);      // backpressure 1,0,0,1,0,1
    run_dump(1022, 4, 0, 1'b0);   // wrap-around
    run_dump(0, 0, 0, 1'b0);      // empty dump
    run_dump(3, 4, 2, 1'b1);      // start while busy is ignored

    // Mid-dump reset after two records, downstream stalled.
    @(negedge clk);
    bus.start = 1'b1; bus.base_idx = 10'd0; bus.count = 11'd4; bus.out_ready = 1'b1;
    acc = 0;
    for (int j = 0; j < 20 && acc < 2; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) acc++;
    end
    chk("acc_before_reset", acc, 2);
    @(negedge clk);
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_done", bus.done, 1'b0);
    end
    run_dump(5, 1, 0, 1'b0);

    // Randomized windows, random backpressure, and a whole-memory pass.
    for (int n = 0; n < 6; n++) begin
      run_dump(int'($urandom_range(0, DMEM_WORDS - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
    end
    run_dump(int'($urandom_range(0, DMEM_WORDS - 1)), DMEM_WORDS, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
